// File: rtl/bcd_display_counter_n_if.sv
// ---------------------------------------------------------------------------
// bcd_display_counter_n_if
//   Bundles the control, count and display signals of bcd_display_counter_n.
//   slave  : the counter/display block itself
//   master : whatever drives the controls and consumes count/seg/an
//
//   en        count enable (0 freezes prescaler and count)
//   up_dn     direction, 1 = up, 0 = down
//   clr       synchronous clear of count and prescaler
//   load      synchronous parallel load of load_val
//   load_val  BCD load value, digit 0 in [3:0]
//   count     current BCD count, digit 0 least significant
//   wrap      one-cycle pulse on overflow/underflow
//   seg       segments a..g, active-low, seg[0] = a
//   an        anodes, active-low one-hot, an[0] = rightmost digit
// ---------------------------------------------------------------------------
interface bcd_display_counter_n_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic                      up_dn;
    logic                      clr;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_val;
    logic [4*NUM_DIGITS-1:0]   count;
    logic                      wrap;
    logic [0:6]                seg;
    logic [NUM_DIGITS-1:0]     an;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  count, wrap, seg, an
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output count, wrap, seg, an
    );
endinterface

// File: rtl/bcd_display_counter_n.sv
// ---------------------------------------------------------------------------
// bcd_display_counter_n
//   N-digit up/down BCD counter with a multiplexed, active-low 7-segment
//   display driver and optional leading-zero blanking.
//
//   clk     system clock, rising edge
//   rst     asynchronous active-high reset
//   if_bus  bcd_display_counter_n_if.slave:
//             en, up_dn, clr, load, load_val  -> controls
//             count, wrap, seg, an            <- count and display pins
//
//   A prescaler produces one count step every TICK_DIV enabled cycles.
//   Each digit is a bcd_digit_cell; the carry/borrow chain between cells is
//   built combinationally so the whole count updates on one edge.
//   A free-running scan divider rotates the displayed digit every
//   2^SCAN_DIV_BITS cycles; an/seg are registered one cycle behind.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// bcd_digit_cell
//   One BCD digit with clear, saturating load and step up/down.
//
//   i_clr       clear to 0 (highest priority)
//   i_load      load i_load_val, nibbles above 9 saturate to 9
//   i_load_val  load nibble
//   i_step      advance this digit by one in direction i_up
//   i_up        1 = increment, 0 = decrement
//   o_digit     current digit value
//   o_is9       digit is 9 (carry condition when counting up)
//   o_is0       digit is 0 (borrow condition down, leading-zero detect)
// ---------------------------------------------------------------------------
module bcd_digit_cell (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_step,
    input  logic       i_up,
    output logic [3:0] o_digit,
    output logic       o_is9,
    output logic       o_is0
);
    logic [3:0] r_digit;
    logic [3:0] w_load_sat;

    assign w_load_sat = (i_load_val > 4'd9) ? 4'd9 : i_load_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit <= 4'd0;
        end else if (i_clr) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= w_load_sat;
        end else if (i_step) begin
            if (i_up)
                r_digit <= (r_digit >= 4'd9) ? 4'd0 : r_digit + 4'd1;
            else
                r_digit <= (r_digit == 4'd0) ? 4'd9 : r_digit - 4'd1;
        end
    end

    assign o_digit = r_digit;
    assign o_is9   = (r_digit == 4'd9);
    assign o_is0   = (r_digit == 4'd0);
endmodule

module bcd_display_counter_n #(
    parameter int NUM_DIGITS    = 4,
    parameter int TICK_DIV      = 100_000_000,
    parameter int SCAN_DIV_BITS = 18,
    parameter int BLANK_LZ      = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    bcd_display_counter_n_if.slave  if_bus
);
    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // -----------------------------------------------------------------------
    // Seven-segment decode, active-low, bit 0 = segment a
    // -----------------------------------------------------------------------
    function automatic logic [0:6] f_seg(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b0000001;
        endcase
        return s;
    endfunction

    // -----------------------------------------------------------------------
    // Prescaler
    // -----------------------------------------------------------------------
    logic [PRE_W-1:0] r_presc;
    logic             w_presc_tc;
    logic             w_tick;

    assign w_presc_tc = (r_presc == PRE_LAST);
    // clr/load take the cycle over: no count step and no wrap
    assign w_tick = if_bus.en & w_presc_tc & ~if_bus.clr & ~if_bus.load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (if_bus.clr || if_bus.load) begin
            r_presc <= '0;
        end else if (if_bus.en) begin
            r_presc <= w_presc_tc ? '0 : r_presc + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Digit array with carry/borrow chain
    //   w_step[i] : digit i moves this cycle
    //   a digit passes the step on when it is at its rollover value
    //   (9 going up, 0 going down); w_step[NUM_DIGITS] is the wrap
    // -----------------------------------------------------------------------
    logic [NUM_DIGITS-1:0][3:0] w_digit;
    logic [NUM_DIGITS-1:0]      w_is9;
    logic [NUM_DIGITS-1:0]      w_is0;
    logic [NUM_DIGITS:0]        w_step;
    logic [NUM_DIGITS-1:0]      w_lz;

    assign w_step[0] = w_tick;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_cell u_cell (
                .clk        (clk),
                .rst        (rst),
                .i_clr      (if_bus.clr),
                .i_load     (if_bus.load),
                .i_load_val (if_bus.load_val[4*gi +: 4]),
                .i_step     (w_step[gi]),
                .i_up       (if_bus.up_dn),
                .o_digit    (w_digit[gi]),
                .o_is9      (w_is9[gi]),
                .o_is0      (w_is0[gi])
            );

            assign w_step[gi+1] = w_step[gi] & (if_bus.up_dn ? w_is9[gi] : w_is0[gi]);

            // w_lz[i]: digits i..NUM_DIGITS-1 are all zero
            if (gi == NUM_DIGITS - 1) begin : g_lz_top
                assign w_lz[gi] = w_is0[gi];
            end else begin : g_lz_mid
                assign w_lz[gi] = w_is0[gi] & w_lz[gi+1];
            end
        end
    endgenerate

    assign if_bus.count = w_digit;

    // wrap is registered so it is seen in the cycle after the rollover edge
    logic r_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_wrap <= 1'b0;
        else     r_wrap <= w_step[NUM_DIGITS];
    end

    assign if_bus.wrap = r_wrap;

    // -----------------------------------------------------------------------
    // Scan divider and digit index (free-running, ignores en/clr/load)
    // -----------------------------------------------------------------------
    logic [SCAN_DIV_BITS-1:0] r_scan;
    logic [IDX_W-1:0]         r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan <= '0;
            r_idx  <= '0;
        end else begin
            r_scan <= r_scan + 1'b1;
            // with one digit IDX_LAST is 0, so the index stays at 0
            if (&r_scan)
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Display registers
    //   a digit above 0 is blanked when it and everything above it is zero,
    //   so digit 0 always shows something
    // -----------------------------------------------------------------------
    logic             w_blank;
    logic [3:0]       w_cur;
    logic [0:6]       r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    assign w_cur   = w_digit[r_idx];
    assign w_blank = (BLANK_LZ != 0) && (r_idx != '0) && w_lz[r_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= 7'b1111111;
        end else if (w_blank) begin
            r_an  <= '1;
            r_seg <= 7'b1111111;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= f_seg(w_cur);
        end
    end

    assign if_bus.an  = r_an;
    assign if_bus.seg = r_seg;
endmodule

// File: tb/tb_bcd_display_counter_n.sv
// ---------------------------------------------------------------------------
// tb_bcd_display_counter_n
//   Two instances (blanking on / off) driven from the same stimulus.
//   A decimal reference model pushes the expected count/wrap/an/seg for
//   every clock edge into a queue; a negedge checker pops and compares.
//   Directed steps in the initial block add fixed-value checks.
// ---------------------------------------------------------------------------
module tb_bcd_display_counter_n;
    localparam int ND       = 4;
    localparam int TICK_DIV = 4;
    localparam int SCAN_B   = 2;

    logic        clk;
    logic        rst;
    logic        en, up_dn, clr, load;
    logic [15:0] load_val;

    int n_cmp = 0;
    int n_err = 0;

    bcd_display_counter_n_if #(.NUM_DIGITS(ND)) bus  ();
    bcd_display_counter_n_if #(.NUM_DIGITS(ND)) bus2 ();

    assign bus.en        = en;
    assign bus.up_dn     = up_dn;
    assign bus.clr       = clr;
    assign bus.load      = load;
    assign bus.load_val  = load_val;
    assign bus2.en       = en;
    assign bus2.up_dn    = up_dn;
    assign bus2.clr      = clr;
    assign bus2.load     = load;
    assign bus2.load_val = load_val;

    bcd_display_counter_n #(
        .NUM_DIGITS(ND), .TICK_DIV(TICK_DIV), .SCAN_DIV_BITS(SCAN_B), .BLANK_LZ(1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .if_bus (bus)
    );

    bcd_display_counter_n #(
        .NUM_DIGITS(ND), .TICK_DIV(TICK_DIV), .SCAN_DIV_BITS(SCAN_B), .BLANK_LZ(0)
    ) dut_nb (
        .clk    (clk),
        .rst    (rst),
        .if_bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    // Reference model (decimal integer count)
    // ---------------------------------------------------------------------
    typedef struct {
        logic [15:0] count;
        logic        wrap;
        logic [3:0]  an;
        logic [0:6]  seg;
        logic [3:0]  an2;
        logic [0:6]  seg2;
    } exp_t;

    exp_t q[$];

    int         P10 [0:4]    = '{1, 10, 100, 1000, 10000};
    logic [0:6] SEGTAB [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};

    int m_cnt = 0, m_pre = 0, m_div = 0, m_idx = 0;

    function automatic int sat_val(input logic [15:0] v);
        int s = 0;
        int nib;
        for (int k = 0; k < 4; k++) begin
            nib = int'(v[4*k +: 4]);
            if (nib > 9) nib = 9;
            s += nib * P10[k];
        end
        return s;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r = '0;
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((n / P10[k]) % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        int   d;
        if (rst) begin
            m_cnt = 0; m_pre = 0; m_div = 0; m_idx = 0;
            e.count = 16'h0; e.wrap = 1'b0;
            e.an  = 4'hF; e.seg  = 7'b1111111;
            e.an2 = 4'hF; e.seg2 = 7'b1111111;
        end else begin
            d      = (m_cnt / P10[m_idx]) % 10;
            e.seg2 = SEGTAB[d];
            e.an2  = ~(4'b0001 << m_idx);
            if (m_idx > 0 && m_cnt < P10[m_idx]) begin
                e.an = 4'hF; e.seg = 7'b1111111;
            end else begin
                e.an = e.an2; e.seg = e.seg2;
            end
            if (m_div == (1 << SCAN_B) - 1) m_idx = (m_idx + 1) % ND;
            m_div = (m_div + 1) % (1 << SCAN_B);
            e.wrap = 1'b0;
            if (clr) begin
                m_cnt = 0; m_pre = 0;
            end else if (load) begin
                m_cnt = sat_val(load_val); m_pre = 0;
            end else if (en) begin
                if (m_pre == TICK_DIV - 1) begin
                    m_pre = 0;
                    if (up_dn) begin
                        if (m_cnt == 9999) begin m_cnt = 0; e.wrap = 1'b1; end
                        else m_cnt++;
                    end else begin
                        if (m_cnt == 0) begin m_cnt = 9999; e.wrap = 1'b1; end
                        else m_cnt--;
                    end
                end else begin
                    m_pre++;
                end
            end
            e.count = to_bcd(m_cnt);
        end
        q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("sb_count", 32'(bus.count), 32'(e.count));
            chk("sb_wrap",  32'(bus.wrap),  32'(e.wrap));
            chk("sb_an",    32'(bus.an),    32'(e.an));
            chk("sb_seg",   32'(bus.seg),   32'(e.seg));
            chk("sb_an_nb", 32'(bus2.an),   32'(e.an2));
            chk("sb_seg_nb",32'(bus2.seg),  32'(e.seg2));
        end
    end

    // ---------------------------------------------------------------------
    // Directed stimulus
    // ---------------------------------------------------------------------
    initial begin
        int n_a, n_b, n_c, n_d;
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0; en = 1'b1;

        // 1: async reset mid-count, then first tick 4 cycles after release
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_an",    32'(bus.an),    32'hF);
        chk("rst_seg",   32'(bus.seg),   32'h7F);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_tick_count", 32'(bus.count), 32'h0);
        @(negedge clk);
        chk("first_tick_count", 32'(bus.count), 32'h1);

        // 2: load 9998 up -> 9999 -> 0000 with wrap
        load = 1'b1; load_val = 16'h9998; up_dn = 1'b1;
        @(negedge clk);
        load = 1'b0;
        chk("load_9998", 32'(bus.count), 32'h9998);
        repeat (4) @(negedge clk);
        chk("up_9999", 32'(bus.count), 32'h9999);
        chk("up_9999_nowrap", 32'(bus.wrap), 32'h0);
        repeat (4) @(negedge clk);
        chk("up_wrap_count", 32'(bus.count), 32'h0);
        chk("up_wrap_pulse", 32'(bus.wrap), 32'h1);
        @(negedge clk);
        chk("up_wrap_end", 32'(bus.wrap), 32'h0);

        // 3: clr then count down through zero, then saturating load
        up_dn = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_count", 32'(bus.count), 32'h0);
        repeat (4) @(negedge clk);
        chk("dn_wrap_count", 32'(bus.count), 32'h9999);
        chk("dn_wrap_pulse", 32'(bus.wrap), 32'h1);
        repeat (4) @(negedge clk);
        chk("dn_9998", 32'(bus.count), 32'h9998);
        load = 1'b1; load_val = 16'hA5F3;
        @(negedge clk);
        load = 1'b0;
        chk("load_sat", 32'(bus.count), 32'h9593);

        // 4: freeze mid-prescaler, display keeps scanning
        repeat (2) @(negedge clk);
        en = 1'b0;
        n_a = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i < 16 && bus.an == 4'b0111) n_a++;
        end
        chk("freeze_count", 32'(bus.count), 32'h9593);
        chk("freeze_scan_slots", 32'(n_a), 32'd4);
        en = 1'b1;
        @(negedge clk);
        chk("resume_hold", 32'(bus.count), 32'h9593);
        @(negedge clk);
        chk("resume_tick", 32'(bus.count), 32'h9592);

        // 5: leading-zero blanking
        en = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 16'h0042;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        n_a = 0; n_b = 0; n_c = 0; n_d = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.an == 4'hF) n_a++;
            if (bus.an == 4'b1101 && bus.seg == 7'b1001100) n_b++;
            if (bus.an == 4'b1110 && bus.seg == 7'b0010010) n_c++;
            if (bus2.an == 4'b0111 && bus2.seg == 7'b0000001) n_d++;
        end
        chk("lz42_blank_slots", 32'(n_a), 32'd8);
        chk("lz42_digit1", 32'(n_b), 32'd4);
        chk("lz42_digit0", 32'(n_c), 32'd4);
        chk("nolz_digit3", 32'(n_d), 32'd4);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        n_a = 0; n_c = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.an == 4'hF) n_a++;
            if (bus.an == 4'b1110 && bus.seg == 7'b0000001) n_c++;
        end
        chk("lz0_blank_slots", 32'(n_a), 32'd12);
        chk("lz0_digit0", 32'(n_c), 32'd4);

        // 6: clr+load on a tick cycle, then load alone on a tick cycle
        en = 1'b1; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1; load = 1'b1; load_val = 16'h1234;
        @(negedge clk);
        clr = 1'b0; load = 1'b0;
        chk("clrld_tick_count", 32'(bus.count), 32'h0);
        chk("clrld_tick_wrap", 32'(bus.wrap), 32'h0);
        repeat (3) @(negedge clk);
        load = 1'b1; load_val = 16'h0777;
        @(negedge clk);
        load = 1'b0;
        chk("ld_tick_count", 32'(bus.count), 32'h0777);
        repeat (3) @(negedge clk);
        chk("ld_presc_restart", 32'(bus.count), 32'h0777);
        @(negedge clk);
        chk("ld_next_tick", 32'(bus.count), 32'h0778);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
